issue_queue: RTL and testbench

//  Parametrised in-order issue buffer between scoreboard and read-operands. It queues decoded

---
 rtl/issue_queue.sv | 112 +++++++++++
 tb/tb_issue_queue.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_queue.sv
// In-order issue buffer: queues decoded instructions, tags each with a
// transaction ID on enqueue and issues up to ISSUE_W per cycle to ready FUs.
module issue_queue #(
    parameter int DEPTH         = 4,
    parameter int ISSUE_W       = 2,
    parameter int DATA_W        = 64,
    parameter int NR_FU         = 8,
    parameter int TRANS_ID_BITS = 3,
    localparam int FU_W         = $clog2(NR_FU),
    localparam int CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               flush_i,
    input  logic                               flush_unissued_i,
    input  logic                               in_valid_i,
    input  logic [DATA_W-1:0]                  in_data_i,
    input  logic [FU_W-1:0]                    in_fu_i,
    output logic                               in_ready_o,
    input  logic [NR_FU-1:0]                   fu_ready_i,
    output logic [ISSUE_W-1:0]                 issue_valid_o,
    output logic [ISSUE_W*DATA_W-1:0]          issue_data_o,
    output logic [ISSUE_W*FU_W-1:0]            issue_fu_o,
    output logic [ISSUE_W*TRANS_ID_BITS-1:0]   issue_trans_id_o,
    output logic [CNT_W-1:0]                   usage_o,
    output logic                               full_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0]        data_q [DEPTH];
    logic [FU_W-1:0]          fu_q   [DEPTH];
    logic [TRANS_ID_BITS-1:0] tid_q  [DEPTH];

    logic [PTR_W-1:0]         rd_ptr;
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         second_ptr;
    logic [CNT_W-1:0]         count;
    logic [TRANS_ID_BITS-1:0] tid_cnt;
    logic                     flush_any;
    logic                     push;
    logic [1:0]               slot_valid;
    logic [CNT_W-1:0]         pops;

    assign flush_any  = flush_i | flush_unissued_i;
    assign in_ready_o = (count < CNT_W'(DEPTH)) && !flush_any;
    assign push       = in_valid_i && in_ready_o;
    assign second_ptr = rd_ptr + PTR_W'(1);
    assign usage_o    = count;
    assign full_o     = (count == CNT_W'(DEPTH));

    // Pick head and head+1 in order; the second slot needs the first and a different FU.
    always_comb begin
        slot_valid = '0;
        if (!flush_any && (count != '0) && fu_ready_i[fu_q[rd_ptr]]) begin
            slot_valid[0] = 1'b1;
            if ((ISSUE_W == 2) && (count >= CNT_W'(2)) && fu_ready_i[fu_q[second_ptr]]
                && (fu_q[second_ptr] != fu_q[rd_ptr])) begin
                slot_valid[1] = 1'b1;
            end
        end
    end

    assign pops          = CNT_W'(slot_valid[0]) + CNT_W'(slot_valid[1]);
    assign issue_valid_o = slot_valid[ISSUE_W-1:0];

    for (genvar k = 0; k < ISSUE_W; k++) begin : g_slot
        logic [PTR_W-1:0] ptr;
        assign ptr = rd_ptr + PTR_W'(k);
        assign issue_data_o[k*DATA_W +: DATA_W]               = data_q[ptr];
        assign issue_fu_o[k*FU_W +: FU_W]                     = fu_q[ptr];
        assign issue_trans_id_o[k*TRANS_ID_BITS +: TRANS_ID_BITS] = tid_q[ptr];

        a_fu_ready: assert property (@(posedge clk_i) disable iff (!rst_ni)
            issue_valid_o[k] |-> fu_ready_i[issue_fu_o[k*FU_W +: FU_W]]);
    end

    // Payload storage; written only on an accepted enqueue, so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (push) begin
            data_q[wr_ptr] <= in_data_i;
            fu_q[wr_ptr]   <= in_fu_i;
            tid_q[wr_ptr]  <= tid_cnt;
        end
    end

    // Pointer, occupancy and trans-ID bookkeeping; flushes override push and pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            tid_cnt <= '0;
        end else if (flush_any) begin
            count  <= '0;
            rd_ptr <= wr_ptr;
            if (flush_i) begin
                tid_cnt <= '0;
            end else if (count != '0) begin
                tid_cnt <= tid_q[rd_ptr];
            end
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + PTR_W'(1);
                tid_cnt <= tid_cnt + TRANS_ID_BITS'(1);
            end
            rd_ptr <= rd_ptr + PTR_W'(pops);
            count  <= count + CNT_W'(push) - pops;
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue against a queue-based reference model.
module tb_issue_queue;

    localparam int DEPTH   = 4;
    localparam int ISSUE_W = 2;
    localparam int DATA_W  = 16;
    localparam int NR_FU   = 4;
    localparam int TID_W   = 3;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [1:0]        fu;
        logic [TID_W-1:0]  tid;
    } ent_t;

    logic                        clk;
    logic                        rst_n;
    logic                        flush;
    logic                        flush_un;
    logic                        in_valid;
    logic [DATA_W-1:0]           in_data;
    logic [1:0]                  in_fu;
    logic                        in_ready;
    logic [NR_FU-1:0]            fu_ready;
    logic [ISSUE_W-1:0]          issue_valid;
    logic [ISSUE_W*DATA_W-1:0]   issue_data;
    logic [ISSUE_W*2-1:0]        issue_fu;
    logic [ISSUE_W*TID_W-1:0]    issue_tid;
    logic [2:0]                  usage;
    logic                        full;

    int n_checks = 0;
    int n_fail   = 0;

    ent_t mq[$];
    int   mtid;

    logic [1:0]        exp_valid;
    logic              exp_ready;
    logic [2:0]        exp_usage;
    ent_t              e0, e1;
    logic [1:0]        obs_valid;
    logic              obs_ready, obs_full;
    logic [2:0]        obs_usage;
    logic [TID_W-1:0]  obs_tid0, obs_tid1;
    logic [1:0]        obs_fu0, obs_fu1;
    logic [DATA_W-1:0] obs_data0, obs_data1;

    issue_queue #(
        .DEPTH(DEPTH), .ISSUE_W(ISSUE_W), .DATA_W(DATA_W),
        .NR_FU(NR_FU), .TRANS_ID_BITS(TID_W)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .flush_unissued_i(flush_un),
        .in_valid_i(in_valid), .in_data_i(in_data), .in_fu_i(in_fu), .in_ready_o(in_ready),
        .fu_ready_i(fu_ready), .issue_valid_o(issue_valid), .issue_data_o(issue_data),
        .issue_fu_o(issue_fu), .issue_trans_id_o(issue_tid), .usage_o(usage), .full_o(full)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic do_reset();
        rst_n = 1'b0; flush = 0; flush_un = 0; in_valid = 0; in_data = '0; in_fu = '0;
        fu_ready = '0;
        mq.delete();
        mtid = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One clock: sample DUT and model expectations at negedge, advance the model at posedge.
    task automatic run_cycle();
        @(negedge clk);
        exp_valid = 2'b00;
        if (!(flush || flush_un) && mq.size() >= 1 && fu_ready[mq[0].fu]) begin
            exp_valid[0] = 1'b1;
            if (mq.size() >= 2 && fu_ready[mq[1].fu] && mq[1].fu != mq[0].fu)
                exp_valid[1] = 1'b1;
        end
        exp_ready = (mq.size() < DEPTH) && !flush && !flush_un;
        exp_usage = 3'(mq.size());
        if (mq.size() >= 1) e0 = mq[0];
        if (mq.size() >= 2) e1 = mq[1];
        obs_valid = issue_valid; obs_ready = in_ready; obs_full = full; obs_usage = usage;
        obs_tid0  = issue_tid[TID_W-1:0];  obs_tid1  = issue_tid[2*TID_W-1:TID_W];
        obs_fu0   = issue_fu[1:0];         obs_fu1   = issue_fu[3:2];
        obs_data0 = issue_data[DATA_W-1:0]; obs_data1 = issue_data[2*DATA_W-1:DATA_W];
        @(posedge clk);
        if (flush || flush_un) begin
            if (flush) mtid = 0;
            else if (mq.size() > 0) mtid = int'(mq[0].tid);
            mq.delete();
        end else begin
            if (exp_valid[0]) void'(mq.pop_front());
            if (exp_valid[1]) void'(mq.pop_front());
            if (in_valid && exp_ready) begin
                mq.push_back('{data: in_data, fu: in_fu, tid: TID_W'(mtid)});
                mtid = (mtid + 1) % (1 << TID_W);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (usage !== 3'd0)       begin n_fail++; $display("[TB] FAIL reset_usage got %0d want 0", usage); end
        n_checks++; if (full !== 1'b0)        begin n_fail++; $display("[TB] FAIL reset_full got %0b want 0", full); end
        n_checks++; if (in_ready !== 1'b1)    begin n_fail++; $display("[TB] FAIL reset_ready got %0b want 1", in_ready); end
        n_checks++; if (issue_valid !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_valid got %b want 00", issue_valid); end
    endtask

    task automatic test_dual_issue();
        do_reset();
        fu_ready = 4'h0; in_valid = 1; in_fu = 2'd1; in_data = 16'hAAAA;
        run_cycle();
        in_fu = 2'd2; in_data = 16'hBBBB;
        run_cycle();
        in_valid = 0; fu_ready = 4'hF;
        run_cycle();
        n_checks++; if (obs_valid !== 2'b11) begin n_fail++; $display("[TB] FAIL dual_valid got %b want 11", obs_valid); end
        n_checks++; if (obs_tid0 !== 3'd0 || obs_tid1 !== 3'd1) begin n_fail++; $display("[TB] FAIL dual_tid got %0d,%0d want 0,1", obs_tid0, obs_tid1); end
        n_checks++; if (obs_data0 !== 16'hAAAA || obs_data1 !== 16'hBBBB) begin n_fail++; $display("[TB] FAIL dual_data got %h,%h want aaaa,bbbb", obs_data0, obs_data1); end
        n_checks++; if (obs_usage !== 3'd2) begin n_fail++; $display("[TB] FAIL dual_usage_before got %0d want 2", obs_usage); end
        run_cycle();
        n_checks++; if (obs_usage !== 3'd0 || obs_valid !== 2'b00) begin n_fail++; $display("[TB] FAIL dual_usage_after got %0d/%b want 0/00", obs_usage, obs_valid); end
    endtask

    task automatic test_same_fu();
        do_reset();
        fu_ready = 4'h0; in_valid = 1; in_fu = 2'd1; in_data = 16'h1111;
        run_cycle();
        in_data = 16'h2222;
        run_cycle();
        in_valid = 0; fu_ready = 4'hF;
        run_cycle();
        n_checks++; if (obs_valid !== 2'b01 || obs_tid0 !== 3'd0) begin n_fail++; $display("[TB] FAIL samefu_first got %b/%0d want 01/0", obs_valid, obs_tid0); end
        run_cycle();
        n_checks++; if (obs_valid !== 2'b01 || obs_tid0 !== 3'd1) begin n_fail++; $display("[TB] FAIL samefu_second got %b/%0d want 01/1", obs_valid, obs_tid0); end
        run_cycle();
        n_checks++; if (obs_usage !== 3'd0) begin n_fail++; $display("[TB] FAIL samefu_empty got %0d want 0", obs_usage); end
    endtask

    task automatic test_full();
        do_reset();
        fu_ready = 4'h0; in_valid = 1;
        for (int k = 0; k < 4; k++) begin
            in_fu = 2'(k); in_data = 16'(16'h100 + k);
            run_cycle();
        end
        run_cycle();
        n_checks++; if (obs_full !== 1'b1 || obs_ready !== 1'b0 || obs_usage !== 3'd4) begin n_fail++; $display("[TB] FAIL full_flags got full=%0b ready=%0b usage=%0d want 1/0/4", obs_full, obs_ready, obs_usage); end
        in_valid = 0; fu_ready = 4'hF;
        run_cycle();
        n_checks++; if (obs_valid !== 2'b11 || obs_tid0 !== 3'd0 || obs_tid1 !== 3'd1) begin n_fail++; $display("[TB] FAIL full_pop1 got %b %0d %0d want 11 0 1", obs_valid, obs_tid0, obs_tid1); end
        run_cycle();
        n_checks++; if (obs_valid !== 2'b11 || obs_tid0 !== 3'd2 || obs_tid1 !== 3'd3 || obs_usage !== 3'd2) begin n_fail++; $display("[TB] FAIL full_pop2 got %b %0d %0d u%0d want 11 2 3 u2", obs_valid, obs_tid0, obs_tid1, obs_usage); end
        run_cycle();
        n_checks++; if (obs_usage !== 3'd0) begin n_fail++; $display("[TB] FAIL full_drained got %0d want 0", obs_usage); end
    endtask

    task automatic test_wrap();
        do_reset();
        fu_ready = 4'hF; in_fu = 2'd0;
        for (int c = 0; c < 12; c++) begin
            in_valid = (c < 10);
            in_data  = 16'(c);
            run_cycle();
            if (c < 10) begin
                n_checks++; if (obs_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL wrap_ready c%0d got %0b want 1", c, obs_ready); end
            end
            if (c >= 1 && c <= 10) begin
                n_checks++; if (obs_valid !== 2'b01 || obs_tid0 !== 3'((c - 1) % 8)) begin n_fail++; $display("[TB] FAIL wrap_tid c%0d got %b/%0d want 01/%0d", c, obs_valid, obs_tid0, (c - 1) % 8); end
            end
        end
    endtask

    task automatic test_flush(input bit hard);
        do_reset();
        fu_ready = 4'hF; in_fu = 2'd0; in_valid = 1;
        for (int k = 0; k < 3; k++) run_cycle();
        in_valid = 0;
        run_cycle();
        fu_ready = 4'h0; in_valid = 1;
        for (int k = 0; k < 3; k++) run_cycle();
        in_valid = 0; fu_ready = 4'hF;
        if (hard) flush = 1; else flush_un = 1;
        run_cycle();
        n_checks++; if (obs_valid !== 2'b00 || obs_ready !== 1'b0 || obs_usage !== 3'd3) begin n_fail++; $display("[TB] FAIL flush_cycle hard=%0b got %b/%0b/u%0d want 00/0/u3", hard, obs_valid, obs_ready, obs_usage); end
        flush = 0; flush_un = 0; in_valid = 1; fu_ready = 4'h0;
        run_cycle();
        n_checks++; if (obs_usage !== 3'd0) begin n_fail++; $display("[TB] FAIL flush_usage hard=%0b got %0d want 0", hard, obs_usage); end
        in_valid = 0; fu_ready = 4'hF;
        run_cycle();
        n_checks++; if (obs_valid !== 2'b01 || obs_tid0 !== (hard ? 3'd0 : 3'd3)) begin n_fail++; $display("[TB] FAIL flush_next_tid hard=%0b got %b/%0d want 01/%0d", hard, obs_valid, obs_tid0, hard ? 0 : 3); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        fu_ready = 4'h0; in_valid = 1;
        for (int k = 0; k < 4; k++) begin
            in_fu = 2'(k);
            run_cycle();
        end
        in_valid = 0; fu_ready = 4'hF;
        #2;
        n_checks++; if (issue_valid !== 2'b11) begin n_fail++; $display("[TB] FAIL rstmid_pre got %b want 11", issue_valid); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (issue_valid !== 2'b00 || usage !== 3'd0 || in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rstmid_async got %b/u%0d/r%0b want 00/u0/r1", issue_valid, usage, in_ready); end
        mq.delete();
        mtid = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1; in_fu = 2'd0; fu_ready = 4'h0;
        run_cycle();
        in_valid = 0; fu_ready = 4'hF;
        run_cycle();
        n_checks++; if (obs_valid !== 2'b01 || obs_tid0 !== 3'd0) begin n_fail++; $display("[TB] FAIL rstmid_tid got %b/%0d want 01/0", obs_valid, obs_tid0); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            flush    = ($urandom_range(0, 19) == 0);
            flush_un = ($urandom_range(0, 14) == 0);
            in_valid = ($urandom_range(0, 2) != 0);
            in_fu    = 2'($urandom_range(0, 3));
            in_data  = 16'($urandom);
            fu_ready = 4'($urandom);
            run_cycle();
            n_checks++; if (obs_usage !== exp_usage) begin n_fail++; $display("[TB] FAIL rnd_usage c%0d got %0d want %0d", c, obs_usage, exp_usage); end
            n_checks++; if (obs_full !== (exp_usage == 3'd4)) begin n_fail++; $display("[TB] FAIL rnd_full c%0d got %0b want %0b", c, obs_full, exp_usage == 3'd4); end
            n_checks++; if (obs_ready !== exp_ready) begin n_fail++; $display("[TB] FAIL rnd_ready c%0d got %0b want %0b", c, obs_ready, exp_ready); end
            n_checks++; if (obs_valid !== exp_valid) begin n_fail++; $display("[TB] FAIL rnd_valid c%0d got %b want %b", c, obs_valid, exp_valid); end
            if (exp_valid[0]) begin
                n_checks++; if (obs_tid0 !== e0.tid || obs_fu0 !== e0.fu || obs_data0 !== e0.data) begin n_fail++; $display("[TB] FAIL rnd_slot0 c%0d got %0d/%0d/%h want %0d/%0d/%h", c, obs_tid0, obs_fu0, obs_data0, e0.tid, e0.fu, e0.data); end
            end
            if (exp_valid[1]) begin
                n_checks++; if (obs_tid1 !== e1.tid || obs_fu1 !== e1.fu || obs_data1 !== e1.data) begin n_fail++; $display("[TB] FAIL rnd_slot1 c%0d got %0d/%0d/%h want %0d/%0d/%h", c, obs_tid1, obs_fu1, obs_data1, e1.tid, e1.fu, e1.data); end
            end
        end
        flush = 0; flush_un = 0; in_valid = 0;
    endtask

    initial begin
        test_reset();
        test_dual_issue();
        test_same_fu();
        test_full();
        test_wrap();
        test_flush(1'b0);
        test_flush(1'b1);
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
